// File: rtl/adder_eval_pkg.sv
// Shared definitions for approximate-adder evaluation monitors: FSM state
// encoding, default operand width / run length, and statistic counter widths.
package adder_eval_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_NUM_SAMPLES = 65536;

    // Sample and error counters must hold NUM_SAMPLES itself (65536 -> 17 bits)
    localparam int CNT_W       = 17;
    // sum_ed is WIDTH+SUM_EXTRA_W bits; covers (2^(WIDTH+1)-2) * 65536
    localparam int SUM_EXTRA_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/approx_adder_err_monitor_if.sv
// Sample bus between a stimulus source / adder under evaluation and the
// error monitor: operands, adder result {Cout,S} and a valid/ready handshake.
interface approx_adder_err_monitor_if
    import adder_eval_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH:0]   in_s;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_s,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_s,
        output in_ready
    );

endinterface

// File: rtl/err_dist_calc.sv
// Combinational exact-sum and error-distance calculation for one sample of
// an approximate adder. Carry-in is zero; ED = |exact - s|.
module err_dist_calc
    import adder_eval_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH:0]   s,
    output logic [WIDTH:0]   exact,
    output logic [WIDTH:0]   ed
);

    // Absolute difference of two unsigned WIDTH+1 values via a signed
    // WIDTH+2 intermediate so the borrow is never lost.
    function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH:0] x,
                                                input logic [WIDTH:0] y);
        logic signed [WIDTH+1:0] d;
        d = $signed({1'b0, x}) - $signed({1'b0, y});
        if (d < 0) begin
            d = -d;
        end
        return d[WIDTH:0];
    endfunction

    assign exact = {1'b0, a} + {1'b0, b};
    assign ed    = abs_diff(exact, s);

endmodule

// File: rtl/approx_adder_err_monitor.sv
// Error-statistics monitor for an approximate adder. Accepts samples in RUN,
// computes the error distance, and accumulates error count, maximum and sum
// of ED through a two-stage pipeline. A run ends after NUM_SAMPLES samples.
module approx_adder_err_monitor
    import adder_eval_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    approx_adder_err_monitor_if.slave     smp,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              err_count,
    output logic [WIDTH:0]                max_ed,
    output logic [WIDTH+SUM_EXTRA_W-1:0]  sum_ed,
    output logic [CNT_W-1:0]              sample_count
);

    localparam int SUM_W = WIDTH + SUM_EXTRA_W;

    state_t           state;
    state_t           state_next;
    logic             rst_meta;
    logic             rst_sync_n;
    logic             accept;
    logic             last_accept;
    logic             clear;
    logic [WIDTH:0]   ed_p0;
    logic [WIDTH:0]   ed_p1;
    logic             vld_p1;
    logic [WIDTH:0]   exact_sum_unused;

    // Reset asserts immediately but releases only on a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    assign accept      = smp.in_valid && smp.in_ready;
    assign last_accept = accept && (sample_count == CNT_W'(NUM_SAMPLES - 1));
    assign clear       = start && ((state == ST_IDLE) || (state == ST_DONE));

    err_dist_calc #(.WIDTH(WIDTH)) u_err_dist (
        .a     (smp.in_a),
        .b     (smp.in_b),
        .s     (smp.in_s),
        .exact (exact_sum_unused),
        .ed    (ed_p0)
    );

    // State register
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (last_accept) state_next = ST_DRAIN;
            // Only stage 1 can hold a sample here; stage 2 absorbs it on this edge
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  if (start) state_next = ST_RUN;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        smp.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state)
            ST_RUN:   begin smp.in_ready = 1'b1; busy = 1'b1; end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Accepted-sample counter, cleared when a run starts
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            sample_count <= '0;
        end else if (clear) begin
            sample_count <= '0;
        end else if (accept) begin
            sample_count <= sample_count + 1'b1;
        end
    end

    // ---- stage 0 -> stage 1: register ED and its valid flag ----
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    // ED payload carries no reset; it is only consumed when vld_p1 is set
    always_ff @(posedge clk) begin
        if (accept) begin
            ed_p1 <= ed_p0;
        end
    end

    // ---- stage 1 -> stage 2: fold ED into the run statistics ----
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else if (clear) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else if (vld_p1) begin
            err_count <= err_count + CNT_W'(ed_p1 != '0);
            sum_ed    <= sum_ed + SUM_W'(ed_p1);
            if (ed_p1 > max_ed) begin
                max_ed <= ed_p1;
            end
        end
    end

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Testbench for approx_adder_err_monitor. Four monitors with different run
// lengths share one stimulus bus; only the started one accepts samples.
// Expected statistics come from a list of error distances computed with
// plain integer arithmetic on every accepted sample.
module tb_approx_adder_err_monitor;
    import adder_eval_pkg::*;

    localparam int W    = 8;
    localparam int NDUT = 4;

    function automatic int ns_of(input int i);
        if (i == 0) return 65536;
        if (i == 1) return 1;
        if (i == 2) return 4;
        return 200;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic [NDUT-1:0]          start_v;
    logic                     in_valid;
    logic [W-1:0]             in_a;
    logic [W-1:0]             in_b;
    logic [W:0]               in_s;
    logic [NDUT-1:0]          rdy;
    logic [NDUT-1:0]          busy_v;
    logic [NDUT-1:0]          done_v;
    logic [CNT_W-1:0]         errc [NDUT];
    logic [CNT_W-1:0]         cnt  [NDUT];
    logic [W:0]               maxe [NDUT];
    logic [W+SUM_EXTRA_W-1:0] sume [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        approx_adder_err_monitor_if #(.WIDTH(W)) sif ();
        assign sif.in_valid = in_valid;
        assign sif.in_a     = in_a;
        assign sif.in_b     = in_b;
        assign sif.in_s     = in_s;
        assign rdy[g]       = sif.in_ready;

        approx_adder_err_monitor #(.WIDTH(W), .NUM_SAMPLES(ns_of(g))) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .start        (start_v[g]),
            .smp          (sif),
            .busy         (busy_v[g]),
            .done         (done_v[g]),
            .err_count    (errc[g]),
            .max_ed       (maxe[g]),
            .sum_ed       (sume[g]),
            .sample_count (cnt[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int eds[$];
    int e_err, e_max, e_sum;

    // Reference statistics over the accepted error distances
    task automatic model(output int err, output int mx, output int sum);
        err = 0; mx = 0; sum = 0;
        foreach (eds[i]) begin
            if (eds[i] != 0) err++;
            if (eds[i] > mx) mx = eds[i];
            sum += eds[i];
        end
    endtask

    task automatic start_pulse(input int sel);
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        eds.delete();
    endtask

    // kind: 0 exhaustive exact, 1 random result, 2 255+255->0, 3 3+1->3, 4 random exact
    // gaps: 0 none, 1 alternate cycles, 2 random
    // Returns at the negedge one cycle after the last acceptance.
    task automatic feed(input int sel, input int n, input int kind, input int gaps,
                        input int mid_start_at);
        int  acc_n = 0;
        int  cyc   = 0;
        bit  ready_ok = 1'b1;
        bit  v, acc;
        int  e;
        while (acc_n < n && cyc < 4 * n + 64) begin
            @(negedge clk);
            v = (gaps == 0) ? 1'b1 : (gaps == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            case (kind)
                0: begin in_a = 8'(acc_n >> 8); in_b = 8'(acc_n); in_s = {1'b0, in_a} + {1'b0, in_b}; end
                1: begin
                    in_a = 8'($urandom); in_b = 8'($urandom);
                    in_s = ($urandom_range(0, 3) == 0) ? {1'b0, in_a} + {1'b0, in_b} : 9'($urandom_range(0, 511));
                end
                2: begin in_a = 8'd255; in_b = 8'd255; in_s = 9'd0; end
                3: begin in_a = 8'd3; in_b = 8'd1; in_s = 9'd3; end
                default: begin in_a = 8'($urandom); in_b = 8'($urandom); in_s = {1'b0, in_a} + {1'b0, in_b}; end
            endcase
            in_valid     = v;
            start_v[sel] = (acc_n == mid_start_at);
            #1;
            if (!rdy[sel]) ready_ok = 1'b0;
            acc = v && rdy[sel];
            e   = int'(in_a) + int'(in_b) - int'(in_s);
            if (e < 0) e = -e;
            @(posedge clk);
            if (acc) begin
                eds.push_back(e);
                acc_n++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid     = 1'b0;
        start_v[sel] = 1'b0;
        n_tests++; if (acc_n !== n) begin n_fail++; $display("FAIL feed%0d_accepted got %0d want %0d", sel, acc_n, n); end
        n_tests++; if (!ready_ok) begin n_fail++; $display("FAIL feed%0d_ready got low want high during RUN", sel); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_v = '0; in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            n_tests++;
            if ({busy_v[i], done_v[i], rdy[i]} !== 3'b000 || errc[i] !== '0 || maxe[i] !== '0 ||
                sume[i] !== '0 || cnt[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d got busy=%0d done=%0d rdy=%0d err=%0d max=%0d sum=%0d cnt=%0d want all 0",
                         i, busy_v[i], done_v[i], rdy[i], errc[i], maxe[i], sume[i], cnt[i]);
            end
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy_v !== '0 || rdy !== '0 || done_v !== '0) begin
            n_fail++; $display("FAIL reset_release_idle got busy=%b rdy=%b done=%b want 0", busy_v, rdy, done_v);
        end
    endtask

    task automatic test_exhaustive_exact();
        start_pulse(0);
        feed(0, 65536, 0, 0, -1);
        n_tests++; if (done_v[0] !== 1'b0) begin n_fail++; $display("FAIL exh_done_early got 1 want 0"); end
        @(negedge clk);
        model(e_err, e_max, e_sum);
        n_tests++; if (int'(errc[0]) !== e_err) begin n_fail++; $display("FAIL exh_err got %0d want %0d", errc[0], e_err); end
        n_tests++; if (int'(maxe[0]) !== e_max) begin n_fail++; $display("FAIL exh_max got %0d want %0d", maxe[0], e_max); end
        n_tests++; if (int'(sume[0]) !== e_sum) begin n_fail++; $display("FAIL exh_sum got %0d want %0d", sume[0], e_sum); end
        n_tests++; if (int'(cnt[0]) !== 65536) begin n_fail++; $display("FAIL exh_cnt got %0d want 65536", cnt[0]); end
        n_tests++; if ({done_v[0], busy_v[0], rdy[0]} !== 3'b100) begin n_fail++; $display("FAIL exh_done got done=%0d busy=%0d rdy=%0d want 1 0 0", done_v[0], busy_v[0], rdy[0]); end
    endtask

    task automatic test_single_or();
        start_pulse(1);
        feed(1, 1, 3, 0, -1);
        @(negedge clk);
        model(e_err, e_max, e_sum);
        n_tests++; if (int'(errc[1]) !== e_err) begin n_fail++; $display("FAIL one_err got %0d want %0d", errc[1], e_err); end
        n_tests++; if (int'(maxe[1]) !== e_max) begin n_fail++; $display("FAIL one_max got %0d want %0d", maxe[1], e_max); end
        n_tests++; if (int'(sume[1]) !== e_sum) begin n_fail++; $display("FAIL one_sum got %0d want %0d", sume[1], e_sum); end
        n_tests++; if (done_v[1] !== 1'b1 || int'(cnt[1]) !== 1) begin n_fail++; $display("FAIL one_done got done=%0d cnt=%0d want 1 1", done_v[1], cnt[1]); end
    endtask

    task automatic test_saturated_four();
        start_pulse(2);
        feed(2, 4, 2, 0, -1);
        n_tests++;
        if (done_v[2] !== 1'b0 || int'(sume[2]) !== eds[0] + eds[1] + eds[2]) begin
            n_fail++; $display("FAIL four_latency got done=%0d sum=%0d want 0 %0d", done_v[2], sume[2], eds[0] + eds[1] + eds[2]);
        end
        @(negedge clk);
        model(e_err, e_max, e_sum);
        n_tests++; if (done_v[2] !== 1'b1) begin n_fail++; $display("FAIL four_done got %0d want 1", done_v[2]); end
        n_tests++; if (int'(errc[2]) !== e_err) begin n_fail++; $display("FAIL four_err got %0d want %0d", errc[2], e_err); end
        n_tests++; if (int'(maxe[2]) !== e_max) begin n_fail++; $display("FAIL four_max got %0d want %0d", maxe[2], e_max); end
        n_tests++; if (int'(sume[2]) !== e_sum) begin n_fail++; $display("FAIL four_sum got %0d want %0d", sume[2], e_sum); end
    endtask

    task automatic test_gapped_four();
        start_pulse(2);
        n_tests++;
        if (errc[2] !== '0 || maxe[2] !== '0 || sume[2] !== '0 || cnt[2] !== '0 || done_v[2] !== 1'b0 || busy_v[2] !== 1'b1) begin
            n_fail++; $display("FAIL gap_clear got err=%0d max=%0d sum=%0d cnt=%0d done=%0d busy=%0d want 0 0 0 0 0 1",
                               errc[2], maxe[2], sume[2], cnt[2], done_v[2], busy_v[2]);
        end
        feed(2, 4, 2, 1, -1);
        n_tests++; if (done_v[2] !== 1'b0) begin n_fail++; $display("FAIL gap_done_early got 1 want 0"); end
        @(negedge clk);
        model(e_err, e_max, e_sum);
        n_tests++; if (done_v[2] !== 1'b1) begin n_fail++; $display("FAIL gap_done got %0d want 1", done_v[2]); end
        n_tests++;
        if (int'(errc[2]) !== e_err || int'(maxe[2]) !== e_max || int'(sume[2]) !== e_sum) begin
            n_fail++; $display("FAIL gap_stats got %0d/%0d/%0d want %0d/%0d/%0d", errc[2], maxe[2], sume[2], e_err, e_max, e_sum);
        end
        // Samples offered while DONE must not disturb the frozen results
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_s = 9'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (int'(sume[2]) !== e_sum || int'(cnt[2]) !== 4 || done_v[2] !== 1'b1) begin
            n_fail++; $display("FAIL gap_frozen got sum=%0d cnt=%0d done=%0d want %0d 4 1", sume[2], cnt[2], done_v[2], e_sum);
        end
    endtask

    task automatic test_reset_mid_run();
        start_pulse(3);
        feed(3, 100, 1, 2, -1);
        n_tests++; if (int'(cnt[3]) !== 100 || busy_v[3] !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got cnt=%0d busy=%0d want 100 1", cnt[3], busy_v[3]); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy_v[3], done_v[3], rdy[3]} !== 3'b000 || errc[3] !== '0 || maxe[3] !== '0 || sume[3] !== '0 || cnt[3] !== '0) begin
            n_fail++; $display("FAIL midrst_clear got busy=%0d done=%0d rdy=%0d err=%0d max=%0d sum=%0d cnt=%0d want all 0",
                               busy_v[3], done_v[3], rdy[3], errc[3], maxe[3], sume[3], cnt[3]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++; if (busy_v[3] !== 1'b0 || rdy[3] !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got busy=%0d rdy=%0d want 0 0", busy_v[3], rdy[3]); end
    endtask

    task automatic test_clean_sweep();
        start_pulse(3);
        feed(3, 200, 1, 2, -1);
        @(negedge clk);
        model(e_err, e_max, e_sum);
        n_tests++; if (int'(errc[3]) !== e_err) begin n_fail++; $display("FAIL sweep_err got %0d want %0d", errc[3], e_err); end
        n_tests++; if (int'(maxe[3]) !== e_max) begin n_fail++; $display("FAIL sweep_max got %0d want %0d", maxe[3], e_max); end
        n_tests++; if (int'(sume[3]) !== e_sum) begin n_fail++; $display("FAIL sweep_sum got %0d want %0d", sume[3], e_sum); end
        n_tests++; if (int'(cnt[3]) !== 200 || done_v[3] !== 1'b1) begin n_fail++; $display("FAIL sweep_done got cnt=%0d done=%0d want 200 1", cnt[3], done_v[3]); end
    endtask

    task automatic test_start_mid_run();
        start_pulse(3);
        feed(3, 200, 1, 0, 80);
        @(negedge clk);
        model(e_err, e_max, e_sum);
        n_tests++;
        if (int'(errc[3]) !== e_err || int'(maxe[3]) !== e_max || int'(sume[3]) !== e_sum) begin
            n_fail++; $display("FAIL midstart_stats got %0d/%0d/%0d want %0d/%0d/%0d", errc[3], maxe[3], sume[3], e_err, e_max, e_sum);
        end
        n_tests++; if (int'(cnt[3]) !== 200 || done_v[3] !== 1'b1) begin n_fail++; $display("FAIL midstart_cnt got cnt=%0d done=%0d want 200 1", cnt[3], done_v[3]); end
    endtask

    task automatic test_restart_from_done();
        start_pulse(3);
        n_tests++;
        if (errc[3] !== '0 || maxe[3] !== '0 || sume[3] !== '0 || cnt[3] !== '0 || done_v[3] !== 1'b0) begin
            n_fail++; $display("FAIL restart_clear got err=%0d max=%0d sum=%0d cnt=%0d done=%0d want all 0",
                               errc[3], maxe[3], sume[3], cnt[3], done_v[3]);
        end
        feed(3, 200, 4, 2, -1);
        @(negedge clk);
        model(e_err, e_max, e_sum);
        n_tests++;
        if (int'(errc[3]) !== e_err || int'(maxe[3]) !== e_max || int'(sume[3]) !== e_sum) begin
            n_fail++; $display("FAIL restart_exact got %0d/%0d/%0d want %0d/%0d/%0d", errc[3], maxe[3], sume[3], e_err, e_max, e_sum);
        end
        n_tests++; if (int'(cnt[3]) !== 200 || done_v[3] !== 1'b1) begin n_fail++; $display("FAIL restart_done got cnt=%0d done=%0d want 200 1", cnt[3], done_v[3]); end
    endtask

    initial begin
        test_reset();
        test_exhaustive_exact();
        test_single_or();
        test_saturated_four();
        test_gapped_four();
        test_reset_mid_run();
        test_clean_sweep();
        test_start_mid_run();
        test_restart_from_done();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/approx_adder_err_monitor.md
APPROX_ADDER_ERR_MONITOR -- requirements
Module: approx_adder_err_monitor

Interface
REQ-001 Parameter: WIDTH, 8, operand width of the adder under evaluation.
REQ-002 Parameter: NUM_SAMPLES, 65536, samples per evaluation run (exhaustive 8-bit sweep).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-006 in_valid  in  1  sample present on in_a/in_b/in_s.
REQ-007 in_ready  out  1  monitor accepts a sample this cycle.
REQ-008 in_a, in_b  in  WIDTH each  operands applied to the adder under evaluation.
REQ-009 in_s  in  WIDTH+1  adder result {Cout,S}.
REQ-010 busy  out  1  high in RUN and DRAIN.
REQ-011 done  out  1  high in DONE; statistics final and stable.
REQ-012 err_count  out  17  samples with nonzero error distance.
REQ-013 max_ed  out  WIDTH+1  largest error distance seen.
REQ-014 sum_ed  out  WIDTH+18  sum of error distances.
REQ-015 sample_count  out  17  samples accepted in the current run.

Function
REQ-016 Sample is accepted only on a cycle with in_valid and in_ready both high.
REQ-017 Exact sum SHALL be in_a+in_b, zero-extended to WIDTH+1 bits; carry-in is zero.
REQ-018 Error distance ED SHALL be |exact - in_s|, unsigned, WIDTH+1 bits.
REQ-019 Pipeline: stage 1 registers ED and a valid flag; stage 2 updates err_count, max_ed and sum_ed.
REQ-020 Statistics SHALL reflect an accepted sample exactly 2 cycles after acceptance.
REQ-021 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-022 IDLE to RUN on start; statistics and sample_count cleared in the same edge.
REQ-023 in_ready = 1 only in RUN.
REQ-024 RUN to DRAIN on acceptance of sample NUM_SAMPLES.
REQ-025 DRAIN to DONE once the pipeline is empty, 2 cycles after the last acceptance.
REQ-026 done asserts on the cycle the FSM enters DONE.
REQ-027 done remains high, with outputs frozen, until the next start.
REQ-028 DONE to RUN on start; all statistics cleared in the same edge.
REQ-029 start in RUN or DRAIN is ignored.
REQ-030 Gaps in in_valid stall the count without affecting the statistics.
REQ-031 Accumulator widths SHALL never overflow at the default parameters.
- Worst case sum_ed = 510 * 65536.

Reset
REQ-032 rst_n low forces IDLE regardless of the current state, including mid-run.
REQ-033 rst_n low clears pipeline valid flags and all statistic outputs to 0.
REQ-034 rst_n low drives in_ready, busy and done to 0.
REQ-035 Deassertion of rst_n SHALL take effect synchronously with clk; no run starts without start.

Structure
REQ-036 Shared package adder_eval_pkg SHALL hold the following.
- State enum.
- Default WIDTH and NUM_SAMPLES.
- Counter width constants.
REQ-037 One sub-module, err_dist_calc, SHALL compute exact sum and ED combinationally.
- Reused by other approximate-adder monitors.

Verification
REQ-038 Exact adder model, exhaustive 65536 samples: err_count=0, max_ed=0, sum_ed=0, sample_count=65536, done=1.
REQ-039 NUM_SAMPLES=1, sample a=3, b=1, s=3 (OR-style result): err_count=1, max_ed=1, sum_ed=1.
REQ-040 NUM_SAMPLES=4, each sample a=255, b=255, s=0: err_count=4, max_ed=510, sum_ed=2040.
REQ-041 Stream from REQ-040 with in_valid low on alternate cycles: identical results.
- done exactly 2 cycles after the 4th acceptance.
REQ-042 rst_n pulsed low after 100 samples: all outputs 0 immediately and FSM in IDLE.
- A subsequent start runs a full clean sweep.
REQ-043 start pulsed mid-RUN: ignored, counts continue.
- start in DONE clears statistics; a second run with the exact model reports all zero.
